// File: rtl/cve2_rvfi_trace_streamer.sv
// RVFI retirement capture FIFO with a four-word valid/ready serializer.
// Each record carries a sequence number; records lost to a full FIFO bump a saturating counter.
module cve2_rvfi_trace_streamer #(
  parameter int unsigned Depth        = 8,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      rvfi_valid,
  input  logic                      rvfi_trap,
  input  logic                      rvfi_intr,
  input  logic [1:0]                rvfi_mode,
  input  logic [4:0]                rvfi_rd_addr,
  input  logic [31:0]               rvfi_rd_wdata,
  input  logic [31:0]               rvfi_pc_rdata,
  input  logic [31:0]               rvfi_insn,
  output logic                      trace_valid_o,
  input  logic                      trace_ready_i,
  output logic [31:0]               trace_data_o,
  output logic                      trace_last_o,
  output logic [$clog2(Depth):0]    fifo_level_o,
  output logic [DropCntWidth-1:0]   drop_count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

  typedef struct packed {
    logic [15:0] seq;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd_addr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
  } rec_t;

  typedef enum logic [2:0] {StEmpty, StHdr, StPc, StInsn, StWdata} state_e;

  rec_t                    mem_q [Depth];
  rec_t                    rec_in;
  rec_t                    head;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]         level_q, level_d;
  logic [15:0]             seq_q, seq_d;
  logic [DropCntWidth-1:0] drop_q, drop_d;
  state_e                  state_q, state_d;
  logic                    attempt, hs, pop, push;

  assign attempt = rvfi_valid & enable_i;
  assign hs      = trace_valid_o & trace_ready_i;
  assign pop     = hs & (state_q == StWdata);
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign push    = attempt & ((level_q < DepthLvl) | pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    rec_in.seq     = seq_q;
    rec_in.trap    = rvfi_trap;
    rec_in.intr    = rvfi_intr;
    rec_in.mode    = rvfi_mode;
    rec_in.rd_addr = rvfi_rd_addr;
    rec_in.pc      = rvfi_pc_rdata;
    rec_in.insn    = rvfi_insn;
    rec_in.wdata   = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    level_d  = level_q + LvlW'(push) - LvlW'(pop);
    seq_d    = attempt ? seq_q + 16'd1 : seq_q;
    drop_d   = drop_q;
    if (attempt && !push && !(&drop_q)) begin
      drop_d = drop_q + DropCntWidth'(1);
    end

    state_d = state_q;
    unique case (state_q)
      StEmpty: if (push) state_d = StHdr;
      StHdr:   if (hs) state_d = StPc;
      StPc:    if (hs) state_d = StInsn;
      StInsn:  if (hs) state_d = StWdata;
      StWdata: if (hs) state_d = (level_d != '0) ? StHdr : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      state_q  <= StEmpty;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rec_in;
    end
  end

  // Output word is a mux of registered state only; zero whenever nothing is held.
  always_comb begin
    trace_data_o = 32'd0;
    trace_last_o = 1'b0;
    unique case (state_q)
      StHdr:   trace_data_o = {4'hA, head.trap, head.intr, head.mode, head.rd_addr, 3'b000,
                               head.seq};
      StPc:    trace_data_o = head.pc;
      StInsn:  trace_data_o = head.insn;
      StWdata: begin
        trace_data_o = head.wdata;
        trace_last_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign trace_valid_o = (level_q != '0);
  assign fifo_level_o  = level_q;
  assign drop_count_o  = drop_q;

endmodule
